// File: rtl/gfe_mulred.sv
// Sequential modular multiplier over GF(P): MSB-first interleaved shift-and-add
// with a reduction after every doubling and every addition, so acc stays canonical.
module gfe_mulred #(
    parameter int P = 3,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic         busy
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W:0]    P_X   = (W + 1)'(P);
    localparam logic [IW-1:0] I_TOP = IW'(W - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and a presented result holds
    // out_valid/out_r stable until out_ready is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc;
    logic [IW-1:0] idx;

    logic [W:0]    a_ext;
    logic [W-1:0]  a_canon;
    logic [W:0]    t_dbl;
    logic [W-1:0]  t_red;
    logic [W:0]    u_sum;
    logic [W-1:0]  acc_next;
    logic          accept;
    logic          deliver;

    assign in_ready = (state == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready;

    // Operand a may be as large as 2^W-1 < 2P, so one subtraction canonicalises it.
    always_comb begin
        a_ext   = {1'b0, in_a};
        a_canon = in_a;
        if (a_ext >= P_X) begin
            a_canon = W'(a_ext - P_X);
        end
    end

    // One step: acc <- (2*acc mod P + b[i]*a) mod P, kept in W+1 bits throughout.
    always_comb begin
        t_dbl = {acc, 1'b0};
        t_red = W'(t_dbl);
        if (t_dbl >= P_X) begin
            t_red = W'(t_dbl - P_X);
        end
        u_sum = {1'b0, t_red};
        if (b_r[idx]) begin
            u_sum = {1'b0, t_red} + {1'b0, a_r};
        end
        acc_next = W'(u_sum);
        if (u_sum >= P_X) begin
            acc_next = W'(u_sum - P_X);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= a_canon;
                        b_r   <= in_b;
                        acc   <= '0;
                        idx   <= I_TOP;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (idx == '0) begin
                        out_valid <= 1'b1;
                        out_r     <= acc_next;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (deliver) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfe_mulred.sv
// Directed bench for gfe_mulred: a P=3 instance for the main scenarios and a
// P=7 instance for the wider-parameter case.
module tb_gfe_mulred;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv3, ir3, ov3, or3, bz3;
    logic [1:0] a3, b3, r3;
    logic       iv7, ir7, ov7, or7, bz7;
    logic [2:0] a7, b7, r7;

    int checks = 0;
    int errors = 0;

    gfe_mulred #(.P(3), .W(2)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(iv3), .in_ready(ir3), .in_a(a3), .in_b(b3),
        .out_valid(ov3), .out_ready(or3), .out_r(r3), .busy(bz3)
    );

    gfe_mulred #(.P(7), .W(3)) dut7 (
        .clk(clk), .rst(rst),
        .in_valid(iv7), .in_ready(ir7), .in_a(a7), .in_b(b7),
        .out_valid(ov7), .out_ready(or7), .out_r(r7), .busy(bz7)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand pair from IDLE, returns the result and the latency in
    // cycles from the accept (lat = -1 when out_valid never arrives).
    task automatic run_op(input bit use7, input logic [2:0] a, input logic [2:0] b,
                          output logic [2:0] r, output int lat);
        lat = -1;
        r   = '0;
        if (!use7) begin
            iv3 = 1'b1; a3 = a[1:0]; b3 = b[1:0]; or3 = 1'b1;
        end else begin
            iv7 = 1'b1; a7 = a; b7 = b; or7 = 1'b1;
        end
        tick();
        if (!use7) iv3 = 1'b0; else iv7 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if ((!use7 && ov3) || (use7 && ov7)) begin
                lat = n;
                r   = use7 ? r7 : {1'b0, r3};
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv3 = 1'b1; a3 = 2'd2; b3 = 2'd2; or3 = 1'b0;
        iv7 = 1'b1; a7 = 3'd5; b7 = 3'd6; or7 = 1'b0;
        tick();
        tick();
        checks++;
        if (ir3 !== 1'b0 || ir7 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b/%b want 0/0", ir3, ir7);
        end
        checks++;
        if (ov3 !== 1'b0 || r3 !== 2'd0 || bz3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs3: ov=%b r=%0d busy=%b want 0 0 0", ov3, r3, bz3);
        end
        checks++;
        if (ov7 !== 1'b0 || r7 !== 3'd0 || bz7 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs7: ov=%b r=%0d busy=%b want 0 0 0", ov7, r7, bz7);
        end
        iv3 = 1'b0;
        iv7 = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (ir3 !== 1'b1 || ir7 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b/%b want 1/1", ir3, ir7);
        end
        tick();
    endtask

    task automatic test_single();
        iv3 = 1'b1; a3 = 2'd2; b3 = 2'd2; or3 = 1'b1;
        tick();
        iv3 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (ir3 !== 1'b0 || bz3 !== 1'b1 || ov3 !== 1'b0) begin
                errors++;
                $display("FAIL single_run_c%0d: ready=%b busy=%b ov=%b want 0 1 0", c, ir3, bz3, ov3);
            end
            tick();
        end
        checks++;
        if (ov3 !== 1'b1 || r3 !== 2'd1 || ir3 !== 1'b0) begin
            errors++;
            $display("FAIL single_done: ov=%b r=%0d ready=%b want 1 1 0", ov3, r3, ir3);
        end
        tick();
        checks++;
        if (ir3 !== 1'b1 || ov3 !== 1'b0 || bz3 !== 1'b0) begin
            errors++;
            $display("FAIL single_after: ready=%b ov=%b busy=%b want 1 0 0", ir3, ov3, bz3);
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] r;
        int lat;
        int exp_r;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                exp_r = ((a % 3) * (b % 3)) % 3;
                run_op(1'b0, 3'(a), 3'(b), r, lat);
                checks++;
                if (lat != 3 || r !== 3'(exp_r)) begin
                    errors++;
                    $display("FAIL exhaustive_%0dx%0d: r=%0d lat=%0d want r=%0d lat=3", a, b, r, lat, exp_r);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        iv3 = 1'b1; a3 = 2'd2; b3 = 2'd1; or3 = 1'b0;
        tick();
        a3 = 2'd1; b3 = 2'd1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (ov3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%b want 1", ov3);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ov3 !== 1'b1 || r3 !== 2'd2 || ir3 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_c%0d: ov=%b r=%0d ready=%b want 1 2 0", c, ov3, r3, ir3);
            end
            tick();
        end
        or3 = 1'b1;
        iv3 = 1'b0;
        tick();
        checks++;
        if (ov3 !== 1'b0 || ir3 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: ov=%b ready=%b want 0 1", ov3, ir3);
        end
        tick();
        checks++;
        if (ov3 !== 1'b0 || bz3 !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_handshake: ov=%b busy=%b want 0 0", ov3, bz3);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] a_tab[3] = '{2'd1, 2'd2, 2'd2};
        logic [1:0] b_tab[3] = '{2'd1, 2'd1, 2'd2};
        logic [1:0] exp_tab[3] = '{2'd1, 2'd2, 2'd1};
        int k = 0;
        int got = 0;
        int last = -1;
        bit pend;
        iv3 = 1'b1; a3 = a_tab[0]; b3 = b_tab[0]; or3 = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            pend = iv3 & ir3;
            if (ov3) begin
                checks++;
                if (r3 !== exp_tab[got]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %0d want %0d", got, r3, exp_tab[got]);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("FAIL b2b_spacing%0d: got %0d want 4", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            tick();
            if (pend) begin
                k++;
                if (k < 3) begin
                    a3 = a_tab[k];
                    b3 = b_tab[k];
                end else begin
                    iv3 = 1'b0;
                end
            end
        end
        iv3 = 1'b0;
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 3", got);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [2:0] r;
        int lat;
        bit rose = 1'b0;
        iv3 = 1'b1; a3 = 2'd2; b3 = 2'd2; or3 = 1'b1;
        tick();
        iv3 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ir3 !== 1'b1 || r3 !== 2'd0 || ov3 !== 1'b0 || bz3 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: ready=%b r=%0d ov=%b busy=%b want 1 0 0 0", ir3, r3, ov3, bz3);
        end
        for (int c = 0; c < 6; c++) begin
            if (ov3) rose = 1'b1;
            tick();
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL midrun_discard: out_valid rose=1 want 0");
        end
        run_op(1'b0, 3'd1, 3'd2, r, lat);
        checks++;
        if (r !== 3'd2 || lat != 3) begin
            errors++;
            $display("FAIL midrun_fresh: r=%0d lat=%0d want 2 3", r, lat);
        end
    endtask

    task automatic test_p7();
        logic [2:0] r;
        int lat;
        run_op(1'b1, 3'd5, 3'd6, r, lat);
        checks++;
        if (r !== 3'd2 || lat != 4) begin
            errors++;
            $display("FAIL p7_5x6: r=%0d lat=%0d want 2 4", r, lat);
        end
        run_op(1'b1, 3'd7, 3'd7, r, lat);
        checks++;
        if (r !== 3'd0) begin
            errors++;
            $display("FAIL p7_7x7: got %0d want 0", r);
        end
        run_op(1'b1, 3'd6, 3'd6, r, lat);
        checks++;
        if (r !== 3'd1) begin
            errors++;
            $display("FAIL p7_6x6: got %0d want 1", r);
        end
        run_op(1'b1, 3'd3, 3'd5, r, lat);
        checks++;
        if (r !== 3'd1) begin
            errors++;
            $display("FAIL p7_3x5: got %0d want 1", r);
        end
        run_op(1'b1, 3'd4, 3'd7, r, lat);
        checks++;
        if (r !== 3'd0) begin
            errors++;
            $display("FAIL p7_4x7: got %0d want 0", r);
        end
    endtask

    initial begin
        rst = 1'b1;
        iv3 = 1'b0; a3 = '0; b3 = '0; or3 = 1'b0;
        iv7 = 1'b0; a7 = '0; b7 = '0; or7 = 1'b0;
        test_reset();
        test_single();
        test_exhaustive();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_p7();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
